// File: rtl/lidar_pkg.sv
// ============================================================================
// lidar_pkg : shared widths and FSM encoding for the laser-spot centroid path
// Rev 1.0
// ============================================================================
`default_nettype none

package lidar_pkg;

    localparam int PIX_W  = 8;
    localparam int N_PIX  = 2048;
    localparam int IDX_W  = 12;
    localparam int FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : unsigned restoring divider, one quotient bit per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int DVD_W = 36,
    parameter int DVS_W = 20,
    parameter int Q_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quotient
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DVS_W-1:0] r_rem;
    logic [Q_W-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [DVS_W-1:0] w_rem_src;
    logic [DVS_W-1:0] w_rem_nxt;
    logic [Q_W-1:0]   w_q_src;
    logic [Q_W-1:0]   w_q_nxt;
    logic [DVS_W:0]   w_shift;
    logic [DVS_W:0]   w_diff;

    // The caller guarantees the quotient fits Q_W bits, so the dividend bits
    // above Q_W already form a partial remainder smaller than the divisor.
    // The first iteration runs in the start cycle itself.
    assign w_rem_src = i_start ? DVS_W'(i_dividend[DVD_W-1:Q_W]) : r_rem;
    assign w_q_src   = i_start ? i_dividend[Q_W-1:0] : r_q;
    assign w_shift   = {w_rem_src, w_q_src[Q_W-1]};
    assign w_diff    = w_shift - {1'b0, i_divisor};
    assign w_rem_nxt = w_diff[DVS_W] ? w_shift[DVS_W-1:0] : w_diff[DVS_W-1:0];
    assign w_q_nxt   = {w_q_src[Q_W-2:0], ~w_diff[DVS_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_rem_nxt;
            r_q    <= w_q_nxt;
            r_cnt  <= CNT_W'(Q_W - 1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_q;

endmodule

`default_nettype wire

// File: rtl/ccd_spot_centroid.sv
// ============================================================================
// ccd_spot_centroid : thresholded peak and sub-pixel centroid of a line scan
// Rev 1.0
// ============================================================================
`default_nettype none

module ccd_spot_centroid
    import lidar_pkg::*;
#(
    parameter int PIX_W  = lidar_pkg::PIX_W,
    parameter int N_PIX  = lidar_pkg::N_PIX,
    parameter int IDX_W  = lidar_pkg::IDX_W,
    parameter int FRAC_W = lidar_pkg::FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    input  logic [PIX_W-1:0]        threshold,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDX_W+FRAC_W-1:0] res_pos,
    output logic [PIX_W-1:0]        res_peak,
    output logic [IDX_W-1:0]        res_peak_idx,
    output logic                    res_no_spot,
    output logic                    overrun
);

    localparam int SW_W  = PIX_W + IDX_W;
    localparam int SIW_W = PIX_W + 2 * IDX_W;
    localparam int POS_W = IDX_W + FRAC_W;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_PIX - 1);

    state_t           r_state;
    logic [PIX_W-1:0] r_thr;
    logic [IDX_W-1:0] r_idx;
    logic [SW_W-1:0]  r_sum_w;
    logic [SIW_W-1:0] r_sum_iw;
    logic [PIX_W-1:0] r_peak;
    logic [IDX_W-1:0] r_peak_idx;
    logic             r_frame_done;
    logic             r_res_valid;
    logic [POS_W-1:0] r_res_pos;
    logic [PIX_W-1:0] r_res_peak;
    logic [IDX_W-1:0] r_res_peak_idx;
    logic             r_res_no_spot;
    logic             r_overrun;

    logic [PIX_W-1:0] w_wt;
    logic [SW_W-1:0]  w_iw;
    logic             w_accept;
    logic             w_handshake;
    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [POS_W-1:0] w_quot;

    assign w_wt        = (pix_data > r_thr) ? pix_data - r_thr : '0;
    assign w_iw        = {{PIX_W{1'b0}}, r_idx} * {{IDX_W{1'b0}}, w_wt};
    assign w_accept    = (r_state == ACCUM) && !r_frame_done && pix_valid && !frame_start;
    assign w_handshake = r_res_valid && res_ready;
    // Sums settle one cycle after the last pixel; division starts from there.
    assign w_div_start = (r_state == ACCUM) && r_frame_done && !frame_start && (r_sum_w != '0);

    seq_divider #(
        .DVD_W (SIW_W + FRAC_W),
        .DVS_W (SW_W),
        .Q_W   (POS_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_abort    (frame_start),
        .i_dividend ({r_sum_iw, {FRAC_W{1'b0}}}),
        .i_divisor  (r_sum_w),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_thr          <= '0;
            r_idx          <= '0;
            r_sum_w        <= '0;
            r_sum_iw       <= '0;
            r_peak         <= '0;
            r_peak_idx     <= '0;
            r_frame_done   <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_pos      <= '0;
            r_res_peak     <= '0;
            r_res_peak_idx <= '0;
            r_res_no_spot  <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (frame_start) begin
            if ((r_state == OUTPUT) && !w_handshake) begin
                r_overrun <= 1'b1;
            end
            r_state      <= ACCUM;
            r_thr        <= threshold;
            r_idx        <= '0;
            r_sum_w      <= '0;
            r_sum_iw     <= '0;
            r_peak       <= '0;
            r_peak_idx   <= '0;
            r_frame_done <= 1'b0;
            r_res_valid  <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_sum_w  <= r_sum_w + SW_W'(w_wt);
                        r_sum_iw <= r_sum_iw + SIW_W'(w_iw);
                        if (pix_data > r_peak) begin
                            r_peak     <= pix_data;
                            r_peak_idx <= r_idx;
                        end
                        if (r_idx == C_LAST_IDX) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (r_frame_done) begin
                        r_frame_done <= 1'b0;
                        if (r_sum_w == '0) begin
                            r_state        <= OUTPUT;
                            r_res_valid    <= 1'b1;
                            r_res_pos      <= '0;
                            r_res_no_spot  <= 1'b1;
                            r_res_peak     <= r_peak;
                            r_res_peak_idx <= r_peak_idx;
                        end else begin
                            r_state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (w_div_done) begin
                        r_state        <= OUTPUT;
                        r_res_valid    <= 1'b1;
                        r_res_pos      <= w_quot;
                        r_res_no_spot  <= 1'b0;
                        r_res_peak     <= r_peak;
                        r_res_peak_idx <= r_peak_idx;
                    end else if (!w_div_busy) begin
                        r_state <= IDLE;
                    end
                end
                OUTPUT: begin
                    if (w_handshake) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign res_valid    = r_res_valid;
    assign res_pos      = r_res_pos;
    assign res_peak     = r_res_peak;
    assign res_peak_idx = r_res_peak_idx;
    assign res_no_spot  = r_res_no_spot;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_ccd_spot_centroid.sv
// ============================================================================
// tb_ccd_spot_centroid : scoreboard bench for the spot centroid block
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ccd_spot_centroid;

    typedef struct packed {
        logic [15:0] pos;
        logic [7:0]  peak;
        logic [11:0] pidx;
        logic        no_spot;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic [7:0]  threshold = 8'd0;
    logic        res_ready = 1'b0;
    logic        res_valid;
    logic [15:0] res_pos;
    logic [7:0]  res_peak;
    logic [11:0] res_peak_idx;
    logic        res_no_spot;
    logic        overrun;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #10 clk = ~clk;

    ccd_spot_centroid dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .threshold    (threshold),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_pos      (res_pos),
        .res_peak     (res_peak),
        .res_peak_idx (res_peak_idx),
        .res_no_spot  (res_no_spot),
        .overrun      (overrun)
    );

    function automatic logic [7:0] pix_of(input int pat, input int i);
        case (pat)
            1: return (i == 100 || i == 102) ? 8'd60 : (i == 101) ? 8'd110 : 8'd0;
            2: return (i == 200) ? 8'd150 : (i == 201) ? 8'd100 : 8'd0;
            3: return 8'd40;
            default: return 8'((i * 73) ^ (i >> 3));
        endcase
    endfunction

    function automatic res_t model(input int pat, input logic [7:0] thr);
        longint sw;
        longint siw;
        int     w;
        logic [7:0] p;
        res_t   r;
        sw  = 0;
        siw = 0;
        r   = '0;
        for (int i = 0; i < 2048; i++) begin
            p = pix_of(pat, i);
            w = (p > thr) ? int'(p) - int'(thr) : 0;
            sw  += longint'(w);
            siw += longint'(i) * longint'(w);
            if (p > r.peak) begin
                r.peak = p;
                r.pidx = 12'(i);
            end
        end
        if (sw == 0) r.no_spot = 1'b1;
        else         r.pos = 16'((siw * 16) / sw);
        return r;
    endfunction

    task automatic start_frame(input logic [7:0] thr, input logic dirty);
        @(negedge clk);
        frame_start = 1'b1;
        threshold   = thr;
        pix_valid   = dirty;
        pix_data    = 8'hC8;
    endtask

    task automatic send_pixels(input int pat, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            threshold   = 8'($urandom);
            pix_valid   = 1'b1;
            pix_data    = pix_of(pat, i);
        end
    endtask

    task automatic collect(input string name, input int exp_lat, input bit do_hs);
        int   n;
        res_t got;
        res_t exp;
        n = 0;
        res_ready = 1'b0;
        do begin
            @(negedge clk);
            pix_valid   = 1'b0;
            frame_start = 1'b0;
            n++;
        end while (!res_valid && n < 200);
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, exp_lat);
        end
        if (!res_valid) return;
        got = {res_pos, res_peak, res_peak_idx, res_no_spot};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected result pos=%0d peak=%0d idx=%0d no_spot=%0d",
                     name, got.pos, got.peak, got.pidx, got.no_spot);
            return;
        end
        exp = exp_q.pop_front();
        if (got !== exp) begin
            errors++;
            $display("FAIL %s result: got pos=%0d peak=%0d idx=%0d no_spot=%0d, expected pos=%0d peak=%0d idx=%0d no_spot=%0d",
                     name, got.pos, got.peak, got.pidx, got.no_spot,
                     exp.pos, exp.peak, exp.pidx, exp.no_spot);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({res_valid, res_pos, res_peak, res_peak_idx, res_no_spot} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL %s hold: got valid=%0d pos=%0d, expected valid=1 pos=%0d",
                     name, res_valid, res_pos, exp.pos);
        end
        if (do_hs) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s drop after handshake: got valid=%0d, expected 0", name, res_valid);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({res_valid, res_pos, res_peak, res_peak_idx, res_no_spot, overrun} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got valid=%0d pos=%0d peak=%0d idx=%0d ns=%0d ovr=%0d, expected all 0",
                     res_valid, res_pos, res_peak, res_peak_idx, res_no_spot, overrun);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = 8'hFF;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle pixels: got valid=%0d, expected 0", res_valid);
        end
    endtask

    task automatic test_centroid();
        int pats[3] = '{1, 2, 4};
        logic [7:0] thrs[3] = '{8'd50, 8'd50, 8'd200};
        for (int k = 0; k < 3; k++) begin
            start_frame(thrs[k], 1'b0);
            send_pixels(pats[k], 0, 2047);
            exp_q.push_back(model(pats[k], thrs[k]));
            collect($sformatf("centroid_p%0d", pats[k]), 18, 1'b1);
        end
    endtask

    task automatic test_no_spot();
        start_frame(8'd50, 1'b0);
        send_pixels(3, 0, 2047);
        exp_q.push_back(model(3, 8'd50));
        collect("no_spot", 2, 1'b1);
    endtask

    task automatic test_overrun();
        start_frame(8'd50, 1'b0);
        send_pixels(1, 0, 2047);
        exp_q.push_back(model(1, 8'd50));
        collect("ovr_first", 18, 1'b0);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun before drop: got %0d, expected 0", overrun);
        end
        repeat (50) @(negedge clk);
        start_frame(8'd50, 1'b0);
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if ({res_valid, overrun} !== 2'b01) begin
            errors++;
            $display("FAIL overrun drop: got valid=%0d ovr=%0d, expected valid=0 ovr=1", res_valid, overrun);
        end
        send_pixels(2, 0, 2047);
        exp_q.push_back(model(2, 8'd50));
        collect("ovr_second", 18, 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun sticky: got %0d, expected 1", overrun);
        end
    endtask

    task automatic test_restart();
        int extra;
        start_frame(8'd50, 1'b0);
        send_pixels(2, 0, 499);
        start_frame(8'd50, 1'b1);
        send_pixels(1, 0, 2047);
        repeat (6) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
        start_frame(8'd50, 1'b0);
        send_pixels(2, 0, 2047);
        exp_q.push_back(model(2, 8'd50));
        collect("restart", 18, 1'b1);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL restart extra results: got %0d valid cycles, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_divide();
        start_frame(8'd50, 1'b0);
        send_pixels(2, 0, 2047);
        repeat (8) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({res_valid, res_pos, res_peak, res_peak_idx, res_no_spot, overrun} !== '0) begin
            errors++;
            $display("FAIL mid-divide reset: got valid=%0d pos=%0d peak=%0d idx=%0d ns=%0d ovr=%0d, expected all 0",
                     res_valid, res_pos, res_peak, res_peak_idx, res_no_spot, overrun);
        end
        rst = 1'b0;
        start_frame(8'd50, 1'b0);
        send_pixels(1, 0, 2047);
        exp_q.push_back(model(1, 8'd50));
        collect("after_reset", 18, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_frame(8'd50, 1'b1);
        send_pixels(1, 0, 2047);
        exp_q.push_back(model(1, 8'd50));
        collect("b2b_first", 18, 1'b0);
        @(negedge clk);
        res_ready   = 1'b1;
        frame_start = 1'b1;
        threshold   = 8'd60;
        @(negedge clk);
        res_ready   = 1'b0;
        frame_start = 1'b0;
        checks++;
        if ({res_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL b2b handshake+start: got valid=%0d ovr=%0d, expected 0 0", res_valid, overrun);
        end
        send_pixels(4, 0, 2047);
        exp_q.push_back(model(4, 8'd60));
        collect("b2b_second", 18, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_centroid();
        test_no_spot();
        test_overrun();
        test_restart();
        test_reset_mid_divide();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
